// File: rtl/spi_updated_pkg.sv
// Shared types and constants for the spi_updated SPI master.
package spi_updated_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam logic [4:0]  COUNT_IDLE = 5'd16;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold
    } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: N-cycle half-period divider, leading/trailing edge strobes and the
// registered SCLK level, which rests at CPOL outside the shifting phase.
module spi_clk_gen #(
    parameter int unsigned N = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic toggle_en_i,
    input  logic load_cpol_i,
    input  logic cpol_i,
    output logic tick_o,
    output logic lead_o,
    output logic trail_o,
    output logic sclk_o
);

    localparam logic [7:0] DivMax = 8'(N - 1);

    logic [7:0] div_q, div_d;
    logic       phase_q, phase_d;
    logic       sclk_q, sclk_d;
    logic       tick;

    always_comb begin
        tick    = run_i && (div_q == DivMax);
        div_d   = div_q + 8'd1;
        phase_d = phase_q;
        sclk_d  = sclk_q;
        if (!run_i || tick) begin
            div_d = '0;
        end
        // phase_q = 0 means the next toggle is the leading edge of a bit
        if (!toggle_en_i) begin
            phase_d = 1'b0;
        end else if (tick) begin
            phase_d = ~phase_q;
        end
        if (load_cpol_i) begin
            sclk_d = cpol_i;
        end else if (toggle_en_i && tick) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

    assign tick_o  = tick;
    assign lead_o  = toggle_en_i && tick && !phase_q;
    assign trail_o = toggle_en_i && tick && phase_q;
    assign sclk_o  = sclk_q;

endmodule

// File: rtl/spi_updated.sv
// 16-bit full-duplex SPI master, four modes, four slave selects. A transfer starts after
// reset release and whenever din differs from the last word sent.
module spi_updated
    import spi_updated_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    input  logic [1:0]        spi_mode,
    input  logic [1:0]        slave_sel,
    output logic [3:0]        ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [4:0]        counter
);

    spi_state_e        state_q, state_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] last_din_q, last_din_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              start_pending_q, start_pending_d;
    logic              cpha_q, cpha_d;
    logic [4:0]        counter_q, counter_d;
    logic              mosi_q, mosi_d;
    logic [3:0]        ss_q, ss_d;
    logic [3:0]        bit_idx;
    logic              tick, lead, trail;

    spi_clk_gen #(
        .N (N)
    ) u_clk_gen (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (state_q != StIdle),
        .toggle_en_i (state_q == StXfer),
        .load_cpol_i (state_q == StIdle),
        .cpol_i      (spi_mode[1]),
        .tick_o      (tick),
        .lead_o      (lead),
        .trail_o     (trail),
        .sclk_o      (sclk)
    );

    assign bit_idx = counter_q[3:0];

    always_comb begin
        state_d         = state_q;
        tx_d            = tx_q;
        rx_d            = rx_q;
        last_din_d      = last_din_q;
        dout_d          = dout_q;
        start_pending_d = start_pending_q;
        cpha_d          = cpha_q;
        counter_d       = counter_q;
        mosi_d          = mosi_q;
        ss_d            = ss_q;

        unique case (state_q)
            StIdle: begin
                ss_d      = 4'hF;
                counter_d = COUNT_IDLE;
                if (start_pending_q || (din != last_din_q)) begin
                    tx_d            = din;
                    last_din_d      = din;
                    cpha_d          = spi_mode[0];
                    start_pending_d = 1'b0;
                    counter_d       = 5'd15;
                    ss_d            = ~(4'b0001 << slave_sel);
                    if (!spi_mode[0]) begin
                        mosi_d = din[WORD_W-1];
                    end
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (lead) begin
                    if (!cpha_q) begin
                        rx_d[bit_idx] = miso;
                    end else begin
                        mosi_d = tx_q[bit_idx];
                    end
                end
                if (trail) begin
                    if (cpha_q) begin
                        rx_d[bit_idx] = miso;
                    end
                    if (counter_q == 5'd0) begin
                        // rx_d already holds bit 0 in CPHA=1, so dout gets all 16 bits
                        counter_d = COUNT_IDLE;
                        dout_d    = rx_d;
                        state_d   = StHold;
                    end else begin
                        counter_d = counter_q - 5'd1;
                        if (!cpha_q) begin
                            mosi_d = tx_q[bit_idx - 4'd1];
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    ss_d    = 4'hF;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            tx_q            <= '0;
            rx_q            <= '0;
            last_din_q      <= '0;
            dout_q          <= '0;
            start_pending_q <= 1'b1;
            cpha_q          <= 1'b0;
            counter_q       <= COUNT_IDLE;
            mosi_q          <= 1'b0;
            ss_q            <= 4'hF;
        end else begin
            state_q         <= state_d;
            tx_q            <= tx_d;
            rx_q            <= rx_d;
            last_din_q      <= last_din_d;
            dout_q          <= dout_d;
            start_pending_q <= start_pending_d;
            cpha_q          <= cpha_d;
            counter_q       <= counter_d;
            mosi_q          <= mosi_d;
            ss_q            <= ss_d;
        end
    end

    assign dout    = dout_q;
    assign ss      = ss_q;
    assign mosi    = mosi_q;
    assign counter = counter_q;

endmodule

// File: tb/tb_spi_updated.sv
// Randomized bench for spi_updated: an N=4 instance against a protocol-level SPI slave model
// and an N=1 instance in loopback, both checked against word-level expectations.
module tb_spi_updated;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [1:0]  spi_mode;
    logic [1:0]  slave_sel;
    logic        miso0;

    logic [15:0] dout0, dout1;
    logic [3:0]  ss0, ss1;
    logic        sclk0, sclk1, mosi0, mosi1;
    logic [4:0]  counter0, counter1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_updated #(.N(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout0),
        .spi_mode  (spi_mode),
        .slave_sel (slave_sel),
        .ss        (ss0),
        .sclk      (sclk0),
        .mosi      (mosi0),
        .miso      (miso0),
        .counter   (counter0)
    );

    spi_updated #(.N(1)) u_dut_n1 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dout      (dout1),
        .spi_mode  (spi_mode),
        .slave_sel (slave_sel),
        .ss        (ss1),
        .sclk      (sclk1),
        .mosi      (mosi1),
        .miso      (mosi1),
        .counter   (counter1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SPI slave model: shifts out slv_pat MSB first, records what it samples on mosi.
    logic [15:0] slv_pat, slv_rx;
    logic        slv_cpol, slv_cpha, slv_lead;
    int          slv_bi = -1;

    initial miso0 = 1'b0;

    always @(ss0) begin
        if (ss0 != 4'hF) begin
            slv_bi   = 15;
            slv_rx   = '0;
            slv_lead = 1'b0;
            if (!slv_cpha) miso0 = slv_pat[15];
        end
    end

    always @(sclk0) begin
        if (ss0 != 4'hF && slv_bi >= 0) begin
            if (sclk0 != slv_cpol) begin
                slv_lead = 1'b1;
                if (!slv_cpha) slv_rx[slv_bi] = mosi0;
                else           miso0 = slv_pat[slv_bi];
            end else if (slv_lead) begin
                slv_lead = 1'b0;
                if (slv_cpha) slv_rx[slv_bi] = mosi0;
                slv_bi--;
                if (!slv_cpha && slv_bi >= 0) miso0 = slv_pat[slv_bi];
            end
        end
    end

    // Per-transfer activity monitors, sampled on the falling clk edge.
    int         busy0, busy1, edges0, edges1, xfers0 = 0, xfers1 = 0, idle_edges0 = 0;
    int         since0, since1, gmin0, gmax0, gmin1, gmax1;
    logic       was0 = 1'b0, was1 = 1'b0, first0, first1, ss_bad0, sprev0 = 1'b0, sprev1 = 1'b0;
    logic [3:0] ss_first0;

    always @(negedge clk) begin
        if (ss0 != 4'hF) begin
            if (!was0) begin
                busy0 = 0; edges0 = 0; since0 = 0; gmin0 = 1000; gmax0 = 0;
                first0 = 1'b1; ss_first0 = ss0; ss_bad0 = 1'b0; xfers0++;
            end
            busy0++;
            since0++;
            if (ss0 != ss_first0) ss_bad0 = 1'b1;
            if (sclk0 != sprev0) begin
                edges0++;
                if (!first0) begin
                    if (since0 < gmin0) gmin0 = since0;
                    if (since0 > gmax0) gmax0 = since0;
                end
                first0 = 1'b0;
                since0 = 0;
            end
        end else if (sclk0 != sprev0) begin
            idle_edges0++;
        end
        if (ss1 != 4'hF) begin
            if (!was1) begin
                busy1 = 0; edges1 = 0; since1 = 0; gmin1 = 1000; gmax1 = 0;
                first1 = 1'b1; xfers1++;
            end
            busy1++;
            since1++;
            if (sclk1 != sprev1) begin
                edges1++;
                if (!first1) begin
                    if (since1 < gmin1) gmin1 = since1;
                    if (since1 > gmax1) gmax1 = since1;
                end
                first1 = 1'b0;
                since1 = 0;
            end
        end
        sprev0 = sclk0;
        sprev1 = sclk1;
        was0   = (ss0 != 4'hF);
        was1   = (ss1 != 4'hF);
    end

    task automatic wait_done(input string tag, input logic [15:0] d, input logic [1:0] mode,
                             input logic [1:0] sel, input logic [15:0] pat, input int x0);
        int         n;
        logic [3:0] exp_ss;
        exp_ss = 4'hF ^ (4'b0001 << sel);
        n = 0;
        while (ss0 == 4'hF && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_started"}, 32'(ss0 != 4'hF), 32'd1);
        n = 0;
        while (ss0 != 4'hF && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ended"}, 32'(ss0 == 4'hF), 32'd1);
        repeat (2) @(negedge clk);
        check_eq({tag, "_ss"}, 32'(ss_first0), 32'(exp_ss));
        check_eq({tag, "_ss_steady"}, 32'(ss_bad0), 32'd0);
        check_eq({tag, "_dout"}, 32'(dout0), 32'(pat));
        check_eq({tag, "_mosi"}, 32'(slv_rx), 32'(d));
        check_eq({tag, "_counter"}, 32'(counter0), 32'd16);
        check_eq({tag, "_busy"}, 32'(busy0), 32'd136);
        check_eq({tag, "_edges"}, 32'(edges0), 32'd32);
        check_eq({tag, "_gap_min"}, 32'(gmin0), 32'd4);
        check_eq({tag, "_gap_max"}, 32'(gmax0), 32'd4);
        check_eq({tag, "_sclk_idle"}, 32'(sclk0), 32'(mode[1]));
        check_eq({tag, "_xfers"}, 32'(xfers0), 32'(x0 + 1));
        check_eq({tag, "_n1_dout"}, 32'(dout1), 32'(d));
        check_eq({tag, "_n1_busy"}, 32'(busy1), 32'd34);
        check_eq({tag, "_n1_edges"}, 32'(edges1), 32'd32);
        check_eq({tag, "_n1_gap"}, 32'(gmax1), 32'd1);
    endtask

    task automatic run_xfer(input string tag, input logic [15:0] d, input logic [1:0] mode,
                            input logic [1:0] sel, input logic [15:0] pat);
        int x0;
        @(negedge clk);
        spi_mode  = mode;
        slave_sel = sel;
        slv_cpol  = mode[1];
        slv_cpha  = mode[0];
        slv_pat   = pat;
        repeat (3) @(negedge clk);
        x0  = xfers0;
        din = d;
        wait_done(tag, d, mode, sel, pat, x0);
    endtask

    function automatic logic [15:0] new_din(input logic [15:0] cur);
        logic [15:0] d;
        do d = 16'($urandom); while (d == cur);
        return d;
    endfunction

    initial begin
        logic [15:0] d, snap;
        int          x0, ie0, n;

        rst       = 1'b1;
        din       = 16'h1234;
        spi_mode  = 2'd0;
        slave_sel = 2'd1;
        slv_cpol  = 1'b0;
        slv_cpha  = 1'b0;
        slv_pat   = 16'hCAFE;
        #1;
        check_eq("rst_dout", 32'(dout0), 32'd0);
        check_eq("rst_ss", 32'(ss0), 32'hF);
        check_eq("rst_sclk", 32'(sclk0), 32'd0);
        check_eq("rst_mosi", 32'(mosi0), 32'd0);
        check_eq("rst_counter", 32'(counter0), 32'd16);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_done("mode0", 16'h1234, 2'd0, 2'd1, 16'hCAFE, 0);

        for (int m = 1; m < 4; m++) begin
            run_xfer($sformatf("mode%0d", m), 16'hA55A, 2'(m), 2'd2, 16'h0F0F);
            run_xfer($sformatf("mode%0d_rnd", m), new_din(din), 2'(m), 2'd0, 16'($urandom));
        end

        for (int s = 0; s < 4; s++) begin
            run_xfer($sformatf("sel%0d", s), new_din(din), 2'($urandom_range(0, 3)), 2'(s),
                     16'($urandom));
        end

        // din held: nothing may move
        snap = dout0;
        x0   = xfers0;
        ie0  = idle_edges0;
        repeat (300) @(negedge clk);
        check_eq("hold_xfers", 32'(xfers0), 32'(x0));
        check_eq("hold_sclk_edges", 32'(idle_edges0), 32'(ie0));
        check_eq("hold_ss", 32'(ss0), 32'hF);
        check_eq("hold_dout", 32'(dout0), 32'(snap));

        for (int r = 0; r < 6; r++) begin
            run_xfer($sformatf("rnd%0d", r), new_din(din), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Abort mid-transfer at counter 7, then the restart must send the same word.
        d = new_din(din);
        run_xfer("pre_abort", d, 2'd1, 2'd3, 16'($urandom));
        d = new_din(din);
        slv_pat = 16'($urandom);
        din = d;
        n = 0;
        while (counter0 != 5'd7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reached_7", 32'(counter0), 32'd7);
        rst = 1'b1;
        #1;
        check_eq("abort_ss", 32'(ss0), 32'hF);
        check_eq("abort_sclk", 32'(sclk0), 32'd0);
        check_eq("abort_counter", 32'(counter0), 32'd16);
        check_eq("abort_dout", 32'(dout0), 32'd0);
        check_eq("abort_mosi", 32'(mosi0), 32'd0);
        slv_pat = 16'($urandom);
        @(negedge clk);
        x0  = xfers0;
        rst = 1'b0;
        wait_done("after_abort", d, 2'd1, 2'd3, slv_pat, x0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
